hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//   Pipeline hazard sequencer in the ID stage, beside the forwarding unit. Resolves the cases
//   forwarding cannot cover:
//   - load-use stalls
//   - multi-cycle mul/div occupancy stalls
//   - branch-mispredict flushes
//   Drives the PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and mul/div start/abort.
//   Keeps saturating stall and flush performance counters.
// PARAMETERS
//   MD_LATENCY  4   total stall cycles per mul/div op, including the start cycle; must be >= 2
//   CNT_W       16  width of the performance counters
// PORTS
//   clk              in   1      clock, rising edge
//   reset            in   1      asynchronous, active-high reset
//   idRs1, idRs2     in   5      source registers of the instruction in ID
//   idUsesRs1/Rs2    in   1      the ID instruction actually reads rs1 / rs2
//   idMulDiv         in   1      the ID instruction is a mul/div
//   exMemRead        in   1      the EX instruction is a load
//   exRd             in   5      destination register of the EX instruction
//   branchMispredict in   1      the EX branch resolved against its prediction (1-cycle pulse)
//   perfClear        in   1      synchronous clear of both counters
//   pcWrite          out  1      PC register write enable
//   ifIdWrite        out  1      IF/ID register write enable
//   idExBubble       out  1      load a NOP into ID/EX
//   ifIdFlush        out  1      load a NOP into IF/ID
//   mdStart          out  1      1-cycle start pulse to the mul/div unit
//   mdAbort          out  1      1-cycle cancel pulse to the mul/div unit
//   busy             out  1      FSM is not in RUN
//   stallCount       out  CNT_W  number of cycles with pcWrite==0 (saturating)
//   flushCount       out  CNT_W  number of accepted mispredicts (saturating)
// BEHAVIOUR
//   Outputs: combinational from state and inputs. State and counters: registered.
//   Reset (async): state=RUN, mdCnt=0, counters=0.
//   While reset is high: pcWrite=ifIdWrite=1; idExBubble, ifIdFlush, mdStart, mdAbort and busy=0.
//   Default output values: pcWrite=ifIdWrite=1, all others 0.
//   STALL means pcWrite=0, ifIdWrite=0 and idExBubble=1.
//   FLUSH means ifIdFlush=1, idExBubble=1 and pcWrite=1 (the redirect target loads).
//   loadUse = exMemRead && exRd!=0 && ((idUsesRs1 && exRd==idRs1) || (idUsesRs2 && exRd==idRs2))
//   State RUN. Evaluate in priority order:
//     1. branchMispredict: FLUSH; stay in RUN.
//     2. loadUse: STALL for 1 cycle; stay in RUN (EX holds a bubble next cycle, so loadUse clears).
//     3. idMulDiv: STALL, mdStart=1, mdCnt<=MD_LATENCY-1; go to MD_WAIT.
//   State MD_WAIT. busy=1.
//     - branchMispredict: FLUSH, mdAbort=1; go to RUN.
//     - otherwise: STALL; mdCnt decrements; when mdCnt==1, go to MD_DONE.
//   State MD_DONE. busy=1. The mul/div instruction advances to EX.
//     - mdStart is suppressed even though idMulDiv is still high.
//     - branchMispredict: FLUSH, no mdAbort.
//     - Always returns to RUN.
//   Latency: mdStart cycle plus MD_WAIT cycles = exactly MD_LATENCY stall cycles, then 1 MD_DONE cycle.
//   Back-to-back mul/div: the second one, now in ID, is detected in RUN on the cycle after MD_DONE.
//   Counters:
//     - stallCount increments on every cycle with pcWrite==0.
//     - flushCount increments on every cycle with branchMispredict==1 outside reset.
//     - Both saturate at all-ones.
//     - perfClear has priority over increment; the clear cycle's event is not counted.
//   Reset mid-mul/div: FSM returns to RUN. No mdAbort is issued; the mul/div unit must share reset.
// TESTING
//   - Load-use: exMemRead=1, exRd=5, idRs2=5, idUsesRs2=1 -> exactly 1 cycle of pcWrite=0 and
//     idExBubble=1, then pcWrite=1; stallCount=1.
//   - Load-use to x0: same as above with exRd=0 -> no stall; stallCount stays 0.
//   - Mul/div, MD_LATENCY=4: idMulDiv=1 at cycle 0 -> mdStart=1 at cycle 0 only; stall on cycles 0-3;
//     cycle 4 is MD_DONE with pcWrite=1 and no mdStart; stallCount=4.
//   - Abort: mispredict at cycle 2 of a mul/div -> ifIdFlush=1, mdAbort=1, pcWrite=1 at cycle 2;
//     RUN at cycle 3; flushCount=1.
//   - Priority: mispredict together with loadUse in RUN -> flush only, pcWrite=1, no stall counted.
//   - Saturation: CNT_W=2, 5 load-use stalls -> stallCount=3.
//     Then perfClear with a coincident stall -> stallCount=0.
//     Then reset asserted in MD_WAIT -> busy=0 immediately and counters=0.

Source files
------------

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - ID-stage hazard sequencer: load-use stalls, mul/div occupancy, mispredict flushes
module hazard_controller #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  logic             idMulDiv,
    input  logic             exMemRead,
    input  logic [4:0]       exRd,
    input  logic             branchMispredict,
    input  logic             perfClear,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExBubble,
    output logic             ifIdFlush,
    output logic             mdStart,
    output logic             mdAbort,
    output logic             busy,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    // $clog2(L) bits are enough to hold the largest count loaded, L-1
    localparam int MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [MDC_W-1:0]   md_cnt, md_cnt_next;
    logic               load_use;

    assign load_use = exMemRead && (exRd != 5'd0) &&
                      ((idUsesRs1 && (exRd == idRs1)) || (idUsesRs2 && (exRd == idRs2)));

    // State and remaining mul/div stall count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next state and pipeline controls; reset forces the pass-through defaults
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExBubble  = 1'b0;
        ifIdFlush   = 1'b0;
        mdStart     = 1'b0;
        mdAbort     = 1'b0;
        busy        = 1'b0;
        if (reset) begin
            state_next  = RUN;
            md_cnt_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (branchMispredict) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                    end else if (load_use) begin
                        pcWrite    = 1'b0;
                        ifIdWrite  = 1'b0;
                        idExBubble = 1'b1;
                    end else if (idMulDiv) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExBubble  = 1'b1;
                        mdStart     = 1'b1;
                        md_cnt_next = MDC_W'(MD_LATENCY - 1);
                        state_next  = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    busy = 1'b1;
                    if (branchMispredict) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                        mdAbort    = 1'b1;
                        state_next = RUN;
                    end else begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExBubble  = 1'b1;
                        md_cnt_next = md_cnt - MDC_W'(1);
                        if (md_cnt == MDC_W'(1)) begin
                            state_next = MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    // The mul/div moves to EX now; idMulDiv is still high but must not restart it
                    busy       = 1'b1;
                    state_next = RUN;
                    if (branchMispredict) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Saturating performance counters; a clear wins over that cycle's event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else if (perfClear) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (!pcWrite && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (branchMispredict && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

endmodule
